lc3b_mem_responder: RTL
=======================

// Module: lc3b_mem_responder
// PURPOSE
//  Memory-side responder for the LC-3b datapath memory interface (mem_read / mem_write / wmask / resp).
//  Services one word-wide read or byte-masked write at a time from an internal word array.
//  Returns mem_resp after a fixed, parameterised latency.
//  Serves as the simulation/FPGA main-memory model behind the control word's mem_read/mem_write.
// PARAMETERS
//  LATENCY    3   cycles from request acceptance to mem_resp pulse; legal range 1..15
//  ADDR_BITS  10  log2 of array depth in 16-bit words; array holds 2**ADDR_BITS words
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   asynchronous, active-high reset
//  mem_read     in   1   read request; held until mem_resp sampled high
//  mem_write    in   1   write request; held until mem_resp sampled high
//  mem_wmask    in   2   byte enables for writes: [0] = low byte [7:0], [1] = high byte [15:8]
//  mem_address  in   16  byte address (lc3b_word); bit 0 ignored, word index = mem_address[ADDR_BITS:1]
//  mem_wdata    in   16  write data
//  mem_resp     out  1   one-cycle completion pulse
//  mem_rdata    out  16  read data; valid in the mem_resp cycle of a read
//  proto_err    out  1   sticky protocol-violation flag
// BEHAVIOUR
//  Reset (async assert, sync release)
//  - state=IDLE, mem_resp=0, mem_rdata=16'h0000, proto_err=0, latency counter=0.
//  - Array contents are not touched by reset. Reset mid-operation aborts the transaction: no write commits.
//  FSM states: IDLE -> BUSY -> RESP -> IDLE
//  - IDLE: if (mem_read | mem_write) at a clock edge, latch address word index, wdata, wmask and
//    op (write wins if both are high); load counter = LATENCY-1; go to BUSY, or straight to RESP if LATENCY==1.
//  - BUSY: decrement counter each edge; at counter==1 go to RESP.
//  - RESP: mem_resp=1 for exactly one cycle, then IDLE unconditionally.
//  - Request seen at edge t -> mem_resp high during cycle t+LATENCY.
//  Data
//  - Write commits at the edge entering RESP, updating only bytes with wmask bit=1.
//  - wmask==2'b00 write: completes normally, no array change.
//  - Read: mem_rdata loaded from array[idx] at the edge entering RESP; holds until the next read completes.
//  - Read-after-write to the same word returns the new data.
//  Addressing
//  - Upper bits above ADDR_BITS are ignored, so addresses wrap modulo 2**(ADDR_BITS+1) bytes.
//  - All request inputs are used only via the latched copies.
//  Handshake rules
//  - Request still high in the IDLE cycle after RESP is a NEW request: back-to-back throughput is
//    one transaction per LATENCY+1 cycles.
//  - Initiator must drop request in the cycle after mem_resp.
//  proto_err is set (sticky until rst) when:
//    (a) mem_read & mem_write are both high in IDLE;
//    (b) the request drops while in BUSY;
//    (c) address, wdata or wmask changes while in BUSY.
//  A transaction that triggers proto_err still completes using the latched values.
// TESTING
//  1. Reset value check: rst pulse -> mem_resp=0, mem_rdata=0, proto_err=0, FSM IDLE.
//  2. LATENCY=3: write 16'hBEEF @0x0040, wmask=11 -> resp 3 cycles after acceptance;
//     read 0x0040 -> resp after 3 cycles, rdata=16'hBEEF.
//  3. Byte masking: write 16'h1234 @0x0010 wmask=11, then 16'hAB00 wmask=10 -> read returns 16'hAB34;
//     wmask=00 write -> still 16'hAB34.
//  4. Wrap-around: ADDR_BITS=10, write 16'h5A5A @0x0802 -> read @0x0002 returns 16'h5A5A;
//     bit 0 set (0x0003) reads the same word.
//  5. Back-to-back: hold mem_read high through resp -> second resp exactly LATENCY+1 cycles after the first.
//  6. Violations: read&write together -> proto_err=1 and write performed;
//     rst asserted in BUSY of a write -> no resp, word unchanged, proto_err=0.

Source files
------------

// File: rtl/lc3b_mem_responder_if.sv
// Request/response bus between the LC-3b datapath (master) and its main-memory responder (slave).
interface lc3b_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        proto_err;

  modport master (
    output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, proto_err
  );

  modport slave (
    input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    output mem_resp, mem_rdata, proto_err
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency word memory behind the LC-3b mem_read/mem_write interface: one transaction at a time,
// byte-masked writes, sticky protocol-violation flag.
module lc3b_mem_responder #(
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  lc3b_mem_responder_if.slave   bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 op_write;
  logic [15:0]          addr_q;
  logic [15:0]          wdata_q;
  logic [1:0]           wmask_q;
  logic                 mem_resp_q;
  logic [15:0]          mem_rdata_q;
  logic                 proto_err_q;

  logic [15:0]          mem [DEPTH];

  // Transaction that completes at the coming edge. With LATENCY==1 it completes on the
  // acceptance edge itself, before the latched copies exist, so IDLE uses the live inputs.
  logic                 req;
  logic                 enter_resp;
  logic                 cur_write;
  logic [ADDR_BITS-1:0] cur_idx;
  logic [15:0]          cur_wdata;
  logic [1:0]           cur_wmask;
  logic                 busy_violation;

  always_comb begin
    req        = bus.mem_read | bus.mem_write;
    cur_write  = op_write;
    cur_idx    = addr_q[ADDR_BITS:1];
    cur_wdata  = wdata_q;
    cur_wmask  = wmask_q;
    enter_resp = 1'b0;
    if (state == IDLE) begin
      cur_write  = bus.mem_write;
      cur_idx    = bus.mem_address[ADDR_BITS:1];
      cur_wdata  = bus.mem_wdata;
      cur_wmask  = bus.mem_wmask;
      enter_resp = req && (LATENCY == 1);
    end else if (state == BUSY) begin
      enter_resp = (cnt == 4'd1);
    end
  end

  // The initiator must hold its own request and every request field stable until mem_resp.
  always_comb begin
    busy_violation = 1'b0;
    if (state == BUSY) begin
      busy_violation = (op_write ? !bus.mem_write : !bus.mem_read)
                     || (bus.mem_address != addr_q)
                     || (bus.mem_wdata   != wdata_q)
                     || (bus.mem_wmask   != wmask_q);
    end
  end

  // NOTE: the array is deliberately left out of reset so it maps onto block RAM and keeps its
  // contents across rst; gating on rst here is what aborts a write caught mid-flight.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_write && !rst) begin
      if (cur_wmask[0]) mem[cur_idx][7:0]  <= cur_wdata[7:0];
      if (cur_wmask[1]) mem[cur_idx][15:8] <= cur_wdata[15:8];
    end
  end

  // NOTE: all control state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      op_write    <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      wmask_q     <= 2'b00;
      mem_resp_q  <= 1'b0;
      mem_rdata_q <= 16'h0000;
      proto_err_q <= 1'b0;
    end else begin
      mem_resp_q <= enter_resp;
      if (enter_resp && !cur_write) begin
        mem_rdata_q <= mem[cur_idx];
      end

      unique case (state)
        IDLE: begin
          if (req) begin
            op_write <= bus.mem_write;
            addr_q   <= bus.mem_address;
            wdata_q  <= bus.mem_wdata;
            wmask_q  <= bus.mem_wmask;
            cnt      <= 4'(LATENCY - 1);
            state    <= (LATENCY == 1) ? RESP : BUSY;
            if (bus.mem_read && bus.mem_write) begin
              proto_err_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
          if (busy_violation) begin
            proto_err_q <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_resp  = mem_resp_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.proto_err = proto_err_q;

endmodule
